// File: rtl/a1csa_pkg.sv
// a1csa_pkg: shared types and elaboration helpers for the a1csa adder family.
package a1csa_pkg;

  // Control states of the variable-latency adder.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DONE = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Number of carry-select blocks for a given operand width and block size.
  function automatic int calc_nb(input int width, input int blk);
    return width / blk;
  endfunction

  // Legal geometry: whole blocks only, and at least two of them.
  function automatic bit blk_fits(input int width, input int blk);
    return (blk > 0) && ((width % blk) == 0) && ((width / blk) >= 2);
  endfunction

endpackage

// File: rtl/a1csa_vl_adder_rb_inc.sv
// rb_inc: BLK-bit recomputing incrementer used to repair a block whose
// carry-in was speculated as 0 but is really 1. Bit 0 flips; every higher
// bit flips when all bits below it are set.
module rb_inc #(
  parameter int BLK = 4
) (
  input  logic [BLK-1:0] din,
  output logic [BLK-1:0] dout
);

  assign dout[0] = ~din[0];

  for (genvar i = 1; i < BLK; i++) begin : g_bit
    assign dout[i] = din[i] ^ (&din[i-1:0]);
  end

endmodule

// File: rtl/a1csa_vl_adder.sv
// a1csa_vl_adder: variable-latency approximate carry-select adder.
// Each block's carry-in is guessed from the previous block's generate alone.
// Build option A1CSA_RECOMPUTE_EN: when defined, mispredicted blocks are
// repaired in an extra FIX cycle (exact results); when undefined, the
// speculative sum/cout are delivered and err flags the inexact result.
module a1csa_vl_adder
  import a1csa_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BLK   = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int NB = calc_nb(WIDTH, BLK);

  if (!blk_fits(WIDTH, BLK)) begin : g_bad_cfg
    $error("a1csa_vl_adder: WIDTH must be a multiple of BLK with at least two blocks");
  end

  state_t           state_r;
  logic             accept_s;
  logic [BLK:0]     raw_s [NB];
  logic [NB-1:0]    g_s;
  logic [NB-2:0]    p_s;
  logic [NB-1:0]    c_spec_s;
  logic [NB-1:0]    c_true_s;
  logic [NB-1:0]    miss_s;
  logic [WIDTH-1:0] s_spec_s;
  logic             err_s;

  assign in_ready = !rst && ((state_r == IDLE) || ((state_r == DONE) && out_ready));
  assign accept_s = in_valid && in_ready;

  // Per-block generate/propagate, speculated vs true carries, speculative sum.
  always_comb begin
    for (int j = 0; j < NB; j++) begin
      raw_s[j] = {1'b0, a[j*BLK +: BLK]} + {1'b0, b[j*BLK +: BLK]};
      g_s[j]   = raw_s[j][BLK];
    end
    for (int j = 0; j < NB - 1; j++) begin
      p_s[j] = &(a[j*BLK +: BLK] ^ b[j*BLK +: BLK]);
    end
    c_spec_s[0] = cin;
    c_true_s[0] = cin;
    for (int j = 1; j < NB; j++) begin
      c_spec_s[j] = g_s[j-1];
      c_true_s[j] = g_s[j-1] | (p_s[j-1] & c_true_s[j-1]);
    end
    // A speculated carry can only be missing, never spurious.
    miss_s = c_true_s & ~c_spec_s;
    err_s  = |miss_s;
    for (int j = 0; j < NB; j++) begin
      s_spec_s[j*BLK +: BLK] = raw_s[j][BLK-1:0] + BLK'(c_spec_s[j]);
    end
  end

`ifdef A1CSA_RECOMPUTE_EN
  logic             cout_true_s;
  logic [NB-1:1]    miss_r;
  logic [WIDTH-1:0] sum_fix_s;

  assign cout_true_s = g_s[NB-1] |
                       ((&(a[(NB-1)*BLK +: BLK] ^ b[(NB-1)*BLK +: BLK])) & c_true_s[NB-1]);

  // Block 0 sees the exact cin, so only blocks 1..NB-1 carry a repair path.
  assign sum_fix_s[BLK-1:0] = sum[BLK-1:0];
  for (genvar j = 1; j < NB; j++) begin : g_fix
    logic [BLK-1:0] inc_blk_s;
    rb_inc #(.BLK(BLK)) u_inc (
      .din  (sum[j*BLK +: BLK]),
      .dout (inc_blk_s)
    );
    assign sum_fix_s[j*BLK +: BLK] = miss_r[j] ? inc_blk_s : sum[j*BLK +: BLK];
  end
`else
  logic cout_spec_s;

  assign cout_spec_s = g_s[NB-1] | ((&raw_s[NB-1][BLK-1:0]) & c_spec_s[NB-1]);
`endif

  // Control FSM with registered result, flag and misprediction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      out_valid <= 1'b0;
      sum       <= {WIDTH{1'b0}};
      cout      <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= {CNT_W{1'b0}};
`ifdef A1CSA_RECOMPUTE_EN
      miss_r    <= {(NB-1){1'b0}};
`endif
    end else if (accept_s) begin
      sum <= s_spec_s;
      err <= err_s;
      if (err_s && (err_cnt != {CNT_W{1'b1}})) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
`ifdef A1CSA_RECOMPUTE_EN
      cout   <= cout_true_s;
      miss_r <= miss_s[NB-1:1];
      if (err_s) begin
        state_r   <= FIX;
        out_valid <= 1'b0;
      end else begin
        state_r   <= DONE;
        out_valid <= 1'b1;
      end
`else
      cout      <= cout_spec_s;
      state_r   <= DONE;
      out_valid <= 1'b1;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          out_valid <= 1'b0;
        end
        FIX: begin
`ifdef A1CSA_RECOMPUTE_EN
          sum       <= sum_fix_s;
          state_r   <= DONE;
          out_valid <= 1'b1;
`else
          state_r   <= IDLE;
          out_valid <= 1'b0;
`endif
        end
        DONE: begin
          if (out_ready) begin
            state_r   <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_a1csa_vl_adder.sv
// tb_a1csa_vl_adder: directed self-checking bench for a1csa_vl_adder
// (WIDTH=16, BLK=4). Expectations follow A1CSA_RECOMPUTE_EN when defined.
module tb_a1csa_vl_adder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        err;
  logic [15:0] err_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  a1csa_vl_adder #(.WIDTH(16), .BLK(4), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] bb_a   [4];
  logic [15:0] bb_b   [4];
  logic [15:0] bb_sum [4];
  logic        bb_co  [4];

  initial begin
    bb_a[0] = 16'h1111; bb_b[0] = 16'h2222; bb_sum[0] = 16'h3333; bb_co[0] = 1'b0;
    bb_a[1] = 16'h0102; bb_b[1] = 16'h0304; bb_sum[1] = 16'h0406; bb_co[1] = 1'b0;
    bb_a[2] = 16'h4000; bb_b[2] = 16'h4000; bb_sum[2] = 16'h8000; bb_co[2] = 1'b0;
    bb_a[3] = 16'h8000; bb_b[3] = 16'h8000; bb_sum[3] = 16'h0000; bb_co[3] = 1'b1;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = 16'h0000; b = 16'h0000; cin = 1'b0;
    cyc();
    cyc();
    chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum",       {16'd0, sum},       32'd0);
    chk("rst_cout",      {31'd0, cout},      32'd0);
    chk("rst_err",       {31'd0, err},       32'd0);
    chk("rst_err_cnt",   {16'd0, err_cnt},   32'd0);

    // Release reset; IDLE is ready regardless of out_ready.
    rst = 1'b0; out_ready = 1'b0;
    #1;
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;

    // 0x0001 + 0x0002: correct speculation, one cycle.
    a = 16'h0001; b = 16'h0002; cin = 1'b0; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("t1_valid",   {31'd0, out_valid}, 32'd1);
    chk("t1_sum",     {16'd0, sum},       32'h0003);
    chk("t1_cout",    {31'd0, cout},      32'd0);
    chk("t1_err",     {31'd0, err},       32'd0);
    chk("t1_err_cnt", {16'd0, err_cnt},   32'd0);
    cyc();
    chk("t1_idle", {31'd0, out_valid}, 32'd0);

    // 0x00FF + 0x0001: block 2 mispredicts, speculative sum 0x0000.
    a = 16'h00FF; b = 16'h0001; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
`ifdef A1CSA_RECOMPUTE_EN
    chk("t2_fix_valid", {31'd0, out_valid}, 32'd0);
    chk("t2_fix_ready", {31'd0, in_ready},  32'd0);
    cyc();
    chk("t2_valid", {31'd0, out_valid}, 32'd1);
    chk("t2_sum",   {16'd0, sum},       32'h0100);
`else
    chk("t2_valid", {31'd0, out_valid}, 32'd1);
    chk("t2_sum",   {16'd0, sum},       32'h0000);
`endif
    chk("t2_cout",    {31'd0, cout},    32'd0);
    chk("t2_err",     {31'd0, err},     32'd1);
    chk("t2_err_cnt", {16'd0, err_cnt}, 32'd1);
    cyc();

    // 0xFFFF + 0x0001: blocks 2 and 3 mispredict.
    a = 16'hFFFF; b = 16'h0001; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
`ifdef A1CSA_RECOMPUTE_EN
    chk("t3_fix_valid", {31'd0, out_valid}, 32'd0);
    cyc();
    chk("t3_valid", {31'd0, out_valid}, 32'd1);
    chk("t3_sum",   {16'd0, sum},       32'h0000);
    chk("t3_cout",  {31'd0, cout},      32'd1);
`else
    chk("t3_valid", {31'd0, out_valid}, 32'd1);
    chk("t3_sum",   {16'd0, sum},       32'hFF00);
    chk("t3_cout",  {31'd0, cout},      32'd0);
`endif
    chk("t3_err",     {31'd0, err},     32'd1);
    chk("t3_err_cnt", {16'd0, err_cnt}, 32'd2);
    cyc();

    // Four back-to-back exact ops at full throughput.
    for (int k = 0; k < 4; k++) begin
      a = bb_a[k]; b = bb_b[k]; in_valid = 1'b1;
      #1;
      chk($sformatf("bb%0d_in_ready", k), {31'd0, in_ready}, 32'd1);
      cyc();
      chk($sformatf("bb%0d_valid", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("bb%0d_sum", k),   {16'd0, sum},       {16'd0, bb_sum[k]});
      chk($sformatf("bb%0d_cout", k),  {31'd0, cout},      {31'd0, bb_co[k]});
      chk($sformatf("bb%0d_err", k),   {31'd0, err},       32'd0);
    end
    in_valid = 1'b0;
    cyc();
    chk("bb_idle", {31'd0, out_valid}, 32'd0);

    // Backpressure: result held stable, no new accept.
    a = 16'h0123; b = 16'h0011; in_valid = 1'b1;
    cyc();
    out_ready = 1'b0;
    a = 16'h0001; b = 16'h0001;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp%0d_in_ready", k), {31'd0, in_ready},  32'd0);
      chk($sformatf("bp%0d_valid", k),    {31'd0, out_valid}, 32'd1);
      chk($sformatf("bp%0d_sum", k),      {16'd0, sum},       32'h0134);
      chk($sformatf("bp%0d_err", k),      {31'd0, err},       32'd0);
      cyc();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    in_valid = 1'b0;
    chk("bp_next_sum",   {16'd0, sum},     32'h0002);
    chk("bp_err_cnt",    {16'd0, err_cnt}, 32'd2);
    cyc();

    // Reset while the mispredicted 0x00FF + 0x0001 op is in flight.
    a = 16'h00FF; b = 16'h0001; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("rf_err_cnt_pre", {16'd0, err_cnt}, 32'd3);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rf_valid",   {31'd0, out_valid}, 32'd0);
    chk("rf_err_cnt", {16'd0, err_cnt},   32'd0);
    chk("rf_sum",     {16'd0, sum},       32'd0);
    chk("rf_err",     {31'd0, err},       32'd0);
    #1;
    chk("rf_idle_ready", {31'd0, in_ready}, 32'd1);
    for (int k = 0; k < 2; k++) begin
      cyc();
      chk($sformatf("rf_quiet%0d", k), {31'd0, out_valid}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/a1csa_vl_adder.md
# a1csa_vl_adder

Parametrised, variable-latency approximate carry-select adder for the a1csa family. Operands are split into BLK-bit blocks whose carry-ins are speculated from the previous block alone. Mispredicted blocks are repaired in one extra cycle by per-block recomputing incrementers. It sits between operand producers and consumers behind a valid/ready handshake, so correctly speculated sums cost one cycle and mispredicted sums cost two.

## Interface
Parameters:
- WIDTH, 16: operand width; must be a multiple of BLK.
- BLK, 4: block size; NB = WIDTH/BLK, NB ≥ 2.
- CNT_W, 16: misprediction counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  operands valid
- in_ready  out  1  block accepts operands
- a, b  in  WIDTH  operands
- cin  in  1  carry-in (exact, feeds block 0)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- cout  out  1  carry-out
- err  out  1  result was mispredicted
- err_cnt  out  CNT_W  saturating count of mispredicted operations

## Operation
- Block j covers bits [j*BLK +: BLK].
- g_j is the carry-out of block j with carry-in 0. p_j = &(a_j ^ b_j).
- Speculated carries: c_spec[0] = cin; c_spec[j] = g_{j-1} for j > 0.
- True carries: c_true[0] = cin; c_true[j+1] = g_j | (p_j & c_true[j]).
- s_spec[j] = a_j + b_j + c_spec[j], truncated to BLK bits. Speculative cout = carry-out of block NB-1 using c_spec[NB-1]. cout = c_true[NB].
- Block j is mispredicted when c_true[j] = 1 and c_spec[j] = 0. The reverse case cannot occur. The per-op error flag is the OR over all blocks.
- Repair: s_fix[j] = s_spec[j] incremented via the recomputing rule: bit i ^= AND of bits [i-1:0] of s_spec[j], and bit 0 is inverted.
- Speculative sum, true carries, error flag and operands are registered on accept, which is the edge where in_valid & in_ready.
- FSM states and transitions:
  - IDLE: accept → FIX if error, else DONE.
  - FIX: go to DONE unconditionally; sum and cout are replaced with the repaired values.
  - DONE: out_valid = 1.
    - out_ready & in_valid: accept new operands, next state FIX or DONE.
    - out_ready & !in_valid: go to IDLE.
    - !out_ready: hold.
- in_ready = !rst & (IDLE | (DONE & out_ready)). in_ready is 0 in FIX.
- err is registered with each result.
- err_cnt increments by 1 per accepted op with error and saturates at all-ones.

## Timing
- Reset values: state IDLE, out_valid 0, sum 0, cout 0, err 0, err_cnt 0. in_ready is 0 while rst is high.
- Latency from accept edge T:
  - out_valid rises after T+1 when there is no error.
  - out_valid rises after T+2 when there is an error and the macro is defined.
- Throughput is 1 op/cycle for correct speculation with out_ready high. Each misprediction inserts one bubble.
- Under backpressure, sum, cout and err stay stable while out_valid & !out_ready.
- rst asserted in any state, including mid-FIX, aborts the operation at the next edge and forces the reset values. The in-flight result is never presented.
- err_cnt updates on the accept edge, not on result delivery.

## Configuration
- A1CSA_RECOMPUTE_EN defined: the FIX state and repair logic are present. Results are exact, and err = 1 marks a result that was repaired.
- A1CSA_RECOMPUTE_EN undefined: FIX is never entered and the recomputing incrementers are not instantiated. Every result is delivered at T+1 with the speculative sum and speculative cout, and err = 1 marks the result inexact.
- err_cnt is present in both configurations.

## Structure
- Shared package a1csa_pkg holds:
  - the state enum (IDLE, DONE, FIX);
  - localparam NB derivation;
  - the WIDTH % BLK == 0 elaboration check.
- Sub-module rb_inc, parametrised by BLK: a BLK-bit recomputing incrementer implementing the repair rule. Instantiate it for blocks 1..NB-1 only; block 0 never mispredicts.

## Test plan
All cases use WIDTH=16, BLK=4, macro defined unless stated.
- a=0x0001, b=0x0002, cin=0 → out_valid after T+1; sum=0x0003, cout=0, err=0, err_cnt unchanged.
- a=0x00FF, b=0x0001, cin=0:
  - Block 2 mispredicts; spec sum is 0x0000.
  - out_valid after T+2; sum=0x0100, cout=0, err=1, err_cnt=1.
  - Macro undefined: out_valid after T+1, sum=0x0000, err=1.
- a=0xFFFF, b=0x0001, cin=0: spec sum 0xFF00, spec cout 0 → repaired sum=0x0000, cout=1, err=1.
- Four back-to-back non-error ops with out_ready=1 → four results on consecutive cycles, in_ready held 1.
- Backpressure: out_ready=0 for 3 cycles with a result in DONE → sum/cout/err stable, in_ready=0, no new accept.
- rst pulsed during FIX of the 0x00FF+0x0001 op → next cycle state IDLE, out_valid=0, err_cnt=0, and the result is never presented.
